// File: rtl/motor_speed_hall_meas.sv
`default_nettype none
// ============================================================================
// Module   : motor_speed_hall_meas
// Brief    : Hall sensor deglitch, sector/direction decode and electrical
//            revolution period measurement (sum of the last six sector times).
// Revision : 1.0 - initial release
// ============================================================================
module motor_speed_hall_meas #(
    parameter int unsigned FILTER_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [2:0]  hall,
    output logic [31:0] motor_speed,
    output logic        new_motor_speed,
    output logic        direction,
    output logic [2:0]  position,
    output logic        stalled,
    output logic        hall_err
);

    localparam logic [7:0]  c_filter  = 8'(FILTER_CYCLES);
    localparam logic [31:0] c_timeout = 32'(TIMEOUT_CYCLES);

    logic [2:0]  r_sync1, r_sync2;
    logic [2:0]  r_cand, r_code;
    logic [7:0]  r_run;
    logic        r_new;
    logic [2:0]  r_pos;
    logic        r_pos_vld, r_armed, r_dir, r_dir_vld;
    logic        r_stalled, r_err, r_strobe;
    logic [31:0] r_cnt, r_sum, r_speed;
    logic [31:0] r_buf [6];
    logic [2:0]  r_wp, r_fill;

    logic [7:0]  w_run;
    logic        w_accept;
    logic        w_dec_ok;
    logic [2:0]  w_dec_sec, w_pos_inc, w_pos_dec;
    logic        w_fwd, w_adj, w_chg, w_push, w_timeout, w_clr;
    logic [31:0] w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= hall;
            r_sync2 <= r_sync1;
        end
    end

    // Run length of the synced code; a code is accepted once it has been
    // stable for c_filter ce cycles and differs from the accepted one.
    assign w_run    = (r_sync2 == r_cand) ? ((r_run == 8'hFF) ? r_run : r_run + 8'd1) : 8'd1;
    assign w_accept = (r_sync2 != r_code) && (w_run >= c_filter);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand <= '0;
            r_run  <= '0;
            r_code <= '0;
            r_new  <= 1'b0;
        end else if (ce) begin
            r_cand <= r_sync2;
            r_run  <= w_run;
            r_new  <= w_accept;
            if (w_accept) begin
                r_code <= r_sync2;
            end
        end
    end

    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_sec = 3'd0;
        case (r_code)
            3'b001:  w_dec_sec = 3'd0;
            3'b011:  w_dec_sec = 3'd1;
            3'b010:  w_dec_sec = 3'd2;
            3'b110:  w_dec_sec = 3'd3;
            3'b100:  w_dec_sec = 3'd4;
            3'b101:  w_dec_sec = 3'd5;
            default: w_dec_ok  = 1'b0;
        endcase
    end

    assign w_pos_inc = (r_pos == 3'd5) ? 3'd0 : r_pos + 3'd1;
    assign w_pos_dec = (r_pos == 3'd0) ? 3'd5 : r_pos - 3'd1;
    assign w_fwd     = (w_dec_sec == w_pos_inc);
    assign w_adj     = r_pos_vld && (w_fwd || (w_dec_sec == w_pos_dec));
    assign w_chg     = r_new && w_dec_ok && (!r_pos_vld || (w_dec_sec != r_pos));
    assign w_push    = w_chg && w_adj && r_armed && r_dir_vld && (w_fwd == r_dir);
    // An accepted sector change in the same cycle suppresses the stall.
    assign w_timeout = !w_chg && !r_stalled && (r_cnt == c_timeout);
    assign w_clr     = (w_chg && !w_push) || w_timeout;
    assign w_sum     = r_sum + r_cnt - r_buf[r_wp];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos     <= '0;
            r_pos_vld <= 1'b0;
            r_armed   <= 1'b0;
            r_dir     <= 1'b0;
            r_dir_vld <= 1'b0;
            r_stalled <= 1'b0;
            r_err     <= 1'b0;
            r_strobe  <= 1'b0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_speed   <= '0;
            r_wp      <= '0;
            r_fill    <= '0;
            for (int i = 0; i < 6; i++) begin
                r_buf[i] <= '0;
            end
        end else if (ce) begin
            r_strobe <= 1'b0;
            if (r_new && !w_dec_ok) begin
                r_err <= 1'b1;
            end
            if (w_chg) begin
                r_cnt     <= 32'd1;
                r_pos     <= w_dec_sec;
                r_pos_vld <= 1'b1;
                r_armed   <= 1'b1;
                r_stalled <= 1'b0;
                if (r_pos_vld && !w_adj) begin
                    r_err <= 1'b1;
                end
                if (w_adj) begin
                    r_dir     <= w_fwd;
                    r_dir_vld <= 1'b1;
                end
            end else if (r_cnt != c_timeout) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_timeout) begin
                r_stalled <= 1'b1;
                r_speed   <= '0;
                r_strobe  <= 1'b1;
                r_armed   <= 1'b0;
            end
            if (w_push) begin
                r_buf[r_wp] <= r_cnt;
                r_sum       <= w_sum;
                r_wp        <= (r_wp == 3'd5) ? 3'd0 : r_wp + 3'd1;
                if (r_fill != 3'd6) begin
                    r_fill <= r_fill + 3'd1;
                end
                if (r_fill >= 3'd5) begin
                    r_speed  <= w_sum;
                    r_strobe <= 1'b1;
                end
            end else if (w_clr) begin
                r_sum  <= '0;
                r_wp   <= '0;
                r_fill <= '0;
                for (int i = 0; i < 6; i++) begin
                    r_buf[i] <= '0;
                end
            end
        end else begin
            r_strobe <= 1'b0;
        end
    end

    assign motor_speed     = r_speed;
    assign new_motor_speed = r_strobe;
    assign direction       = r_dir;
    assign position        = r_pos;
    assign stalled         = r_stalled;
    assign hall_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_motor_speed_hall_meas.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_speed_hall_meas
// Brief    : Directed and randomized bench for motor_speed_hall_meas against a
//            timestamp/queue based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_speed_hall_meas;

    localparam int F  = 4;
    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [2:0]  hall;
    logic [31:0] motor_speed;
    logic        new_motor_speed;
    logic        direction;
    logic [2:0]  position;
    logic        stalled;
    logic        hall_err;

    motor_speed_hall_meas #(
        .FILTER_CYCLES  (F),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .ce              (ce),
        .hall            (hall),
        .motor_speed     (motor_speed),
        .new_motor_speed (new_motor_speed),
        .direction       (direction),
        .position        (position),
        .stalled         (stalled),
        .hall_err        (hall_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [2:0]  pin_q [$];
    logic [2:0]  win [$];
    int unsigned ivq [$];
    logic [2:0]  m_acc, m_pcode;
    bit          m_pend;
    int unsigned ce_idx, m_last;
    int          m_pos;
    bit          m_pos_known, m_armed, m_dir, m_dir_known;
    bit          m_stalled, m_err, m_strobe;
    int unsigned m_speed;

    logic [2:0] seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    int          n_strobe = 0;

    function automatic int decode(input logic [2:0] c);
        for (int i = 0; i < 6; i++) begin
            if (seq[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic m_edge(input logic [2:0] h, input logic c, input logic r);
        logic [2:0]  seen;
        int          s, d;
        bit          changed, same, fwd;
        int unsigned age, sum;
        if (r) begin
            pin_q.delete();
            pin_q.push_back(3'b000);
            pin_q.push_back(3'b000);
            win.delete();
            ivq.delete();
            m_acc = 0; m_pcode = 0; m_pend = 0;
            ce_idx = 0; m_last = 0;
            m_pos = 0; m_pos_known = 0; m_armed = 0; m_dir = 0; m_dir_known = 0;
            m_stalled = 0; m_err = 0; m_strobe = 0; m_speed = 0;
            return;
        end
        seen = pin_q.pop_front();
        pin_q.push_back(h);
        m_strobe = 0;
        if (!c) return;
        age = ce_idx - m_last;
        if (age > TO) age = TO;
        changed = 0;
        if (m_pend) begin
            s = decode(m_pcode);
            if (s < 0) begin
                m_err = 1;
            end else if (!m_pos_known || s != m_pos) begin
                changed = 1;
                if (!m_pos_known) begin
                    m_dir_known = 0;
                end else begin
                    d = (s - m_pos + 6) % 6;
                    if (d != 1 && d != 5) begin
                        m_err = 1;
                        ivq.delete();
                    end else begin
                        fwd = (d == 1);
                        if (!m_armed) begin
                            m_dir = fwd; m_dir_known = 1;
                        end else if (!m_dir_known || fwd != m_dir) begin
                            m_dir = fwd; m_dir_known = 1;
                            ivq.delete();
                        end else begin
                            ivq.push_back(age);
                            if (ivq.size() > 6) void'(ivq.pop_front());
                            if (ivq.size() == 6) begin
                                sum = 0;
                                foreach (ivq[i]) sum += ivq[i];
                                m_speed  = sum;
                                m_strobe = 1;
                            end
                        end
                    end
                end
                m_armed = 1;
                m_pos = s; m_pos_known = 1; m_stalled = 0;
                m_last = ce_idx;
            end
        end
        if (!changed && !m_stalled && age >= TO) begin
            m_stalled = 1; m_speed = 0; m_strobe = 1; m_armed = 0;
            ivq.delete();
        end
        win.push_back(seen);
        if (win.size() > F) void'(win.pop_front());
        m_pend = 0;
        if (win.size() == F) begin
            same = 1;
            foreach (win[i]) if (win[i] != win[0]) same = 0;
            if (same && win[0] != m_acc) begin
                m_acc = win[0]; m_pend = 1; m_pcode = win[0];
            end
        end
        ce_idx++;
    endtask

    task automatic tick(input logic [2:0] h, input logic c, input logic r);
        hall = h; ce = c; rst = r;
        @(posedge clk);
        m_edge(h, c, r);
        @(negedge clk);
        check("position", 32'(position), 32'(m_pos));
        check("direction", 32'(direction), 32'(m_dir));
        check("motor_speed", motor_speed, m_speed);
        check("new_motor_speed", 32'(new_motor_speed), 32'(m_strobe));
        check("stalled", 32'(stalled), 32'(m_stalled));
        check("hall_err", 32'(hall_err), 32'(m_err));
        if (new_motor_speed === 1'b1) n_strobe++;
    endtask

    task automatic hold(input logic [2:0] h, input int n);
        for (int k = 0; k < n; k++) tick(h, 1'b1, 1'b0);
    endtask

    task automatic step_watch(input logic [2:0] h, input int n, output int first_k, output logic [31:0] spd);
        first_k = -1;
        spd     = '0;
        for (int k = 0; k < n; k++) begin
            tick(h, 1'b1, 1'b0);
            if (new_motor_speed === 1'b1 && first_k < 0) begin
                first_k = k;
                spd     = motor_speed;
            end
        end
    endtask

    initial begin
        int          cur, fk, n0, r, dw, gl;
        logic [31:0] spd;
        logic [2:0]  code;
        bit          cm;

        // Reset
        for (int i = 0; i < 3; i++) tick(3'b001, 1'b1, 1'b1);
        check("rst_speed", motor_speed, 32'd0);
        check("rst_strobe", 32'(new_motor_speed), 32'd0);
        check("rst_dir", 32'(direction), 32'd0);
        check("rst_pos", 32'(position), 32'd0);
        check("rst_stalled", 32'(stalled), 32'd0);
        check("rst_err", 32'(hall_err), 32'd0);
        n0 = n_strobe;
        hold(3'b001, 6);
        check("pos_after_rst", 32'(position), 32'd0);
        check("no_strobe_after_rst", 32'(n_strobe - n0), 32'd0);
        hold(3'b001, 94);
        cur = 0;

        // Forward rotation, 100 cycles per sector
        for (int i = 1; i <= 9; i++) begin
            cur = (cur + 1) % 6;
            step_watch(seq[cur], 100, fk, spd);
            if (i <= 6) begin
                check("fwd_no_strobe", 32'(fk), 32'(-1));
            end else begin
                check("fwd_strobe_latency", 32'(fk), 32'd6);
                check("fwd_speed", spd, 32'd600);
                check("fwd_dir", 32'(direction), 32'd1);
            end
        end

        // 3-cycle glitch is rejected; the sector dwell becomes 200
        n0 = n_strobe;
        hold(seq[cur], 40);
        hold(seq[(cur + 1) % 6], 3);
        hold(seq[cur], 57);
        check("glitch3_no_strobe", 32'(n_strobe - n0), 32'd0);
        check("glitch3_pos", 32'(position), 32'(cur));
        cur = (cur + 1) % 6;
        step_watch(seq[cur], 100, fk, spd);
        check("glitch3_latency", 32'(fk), 32'd6);
        check("glitch3_speed", spd, 32'd700);

        // 4-cycle pulse is accepted
        for (int k = 0; k < 100; k++) begin
            tick((k < 4) ? seq[(cur + 1) % 6] : seq[cur], 1'b1, 1'b0);
            if (k == 7) check("glitch4_pos", 32'(position), 32'((cur + 1) % 6));
        end

        // Re-lock forward
        for (int i = 1; i <= 7; i++) begin
            cur = (cur + 1) % 6;
            step_watch(seq[cur], 100, fk, spd);
        end
        check("relock_latency", 32'(fk), 32'd6);
        check("relock_speed", spd, 32'd600);

        // Stall
        n0 = n_strobe;
        hold(seq[cur], 1100);
        check("stall_strobes", 32'(n_strobe - n0), 32'd1);
        check("stall_flag", 32'(stalled), 32'd1);
        check("stall_speed", motor_speed, 32'd0);
        cur = (cur + 1) % 6;
        step_watch(seq[cur], 100, fk, spd);
        check("stall_clear", 32'(stalled), 32'd0);
        check("stall_rearm_no_strobe", 32'(fk), 32'(-1));
        for (int i = 1; i <= 6; i++) begin
            cur = (cur + 1) % 6;
            step_watch(seq[cur], 100, fk, spd);
            if (i < 6) begin
                check("post_stall_no_strobe", 32'(fk), 32'(-1));
            end else begin
                check("post_stall_speed", spd, 32'd600);
            end
        end

        // Reversal at 150 cycles per sector
        cur = (cur + 5) % 6;
        step_watch(seq[cur], 150, fk, spd);
        check("rev_no_strobe", 32'(fk), 32'(-1));
        check("rev_dir", 32'(direction), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            cur = (cur + 5) % 6;
            step_watch(seq[cur], 150, fk, spd);
            if (i < 6) begin
                check("rev_wait_no_strobe", 32'(fk), 32'(-1));
            end else begin
                check("rev_latency", 32'(fk), 32'd6);
                check("rev_speed", spd, 32'd900);
                check("rev_dir_hold", 32'(direction), 32'd0);
            end
        end

        // Faults
        hold(3'b111, 10);
        hold(seq[cur], 50);
        check("invalid_err", 32'(hall_err), 32'd1);
        check("invalid_pos", 32'(position), 32'(cur));
        cur = (cur + 2) % 6;
        step_watch(seq[cur], 100, fk, spd);
        check("skip_err", 32'(hall_err), 32'd1);
        check("skip_no_strobe", 32'(fk), 32'(-1));
        tick(seq[cur], 1'b1, 1'b1);
        tick(seq[cur], 1'b1, 1'b1);
        check("rst_clears_err", 32'(hall_err), 32'd0);

        // Randomized segments
        for (int seg = 0; seg < 200; seg++) begin
            r    = int'($urandom_range(0, 99));
            dw   = int'($urandom_range(5, 250));
            cm   = ((seg % 4) == 3);
            code = seq[cur];
            if (r < 60) begin
                cur = (cur + 1) % 6; code = seq[cur];
            end else if (r < 75) begin
                cur = (cur + 5) % 6; code = seq[cur];
            end else if (r < 82) begin
                cur = (cur + 2 + int'($urandom_range(0, 2))) % 6; code = seq[cur];
            end else if (r < 86) begin
                code = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
            end else if (r < 90) begin
                gl = int'($urandom_range(1, 3));
                for (int k = 0; k < gl; k++) tick(seq[(cur + 1) % 6], 1'b1, 1'b0);
            end else if (r < 92) begin
                tick(code, 1'b1, 1'b1);
                tick(code, 1'b1, 1'b1);
            end else if (r < 96) begin
                dw = 1100;
            end
            for (int k = 0; k < dw; k++) begin
                tick(code, cm ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_speed_hall_meas.md
Name: motor_speed_hall_meas

Overview:
- Upstream stage of the motor-control PID core. Produces its `motor_speed` / `new_motor_speed` inputs from the three motor Hall sensors.
- Synchronises and deglitches the Hall lines, then decodes the commutation sector and direction.
- Times each sector in clk cycles and reports the period of one full electrical revolution, which is the sum of the last 6 sector intervals.
- Flags a stall and reports speed 0 when the rotor stops.

Parameters:
- FILTER_CYCLES, 16: consecutive ce cycles a new Hall code must be stable before it is accepted (range 1..255).
- TIMEOUT_CYCLES, 100000000: interval count at which the motor is declared stalled. Constraint: 6*TIMEOUT_CYCLES < 2^32.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- ce, input, 1: clock enable. At 0, all state except the input synchroniser holds.
- hall, input, 3: raw asynchronous Hall sensor lines {C,B,A}.
- motor_speed, output, 32: electrical revolution period in clk cycles. 0 means stopped or unknown.
- new_motor_speed, output, 1: single-cycle strobe. motor_speed is updated on the same cycle.
- direction, output, 1: 1 = forward (ascending sector), 0 = reverse.
- position, output, 3: current sector 0..5.
- stalled, output, 1: high while the motor is timed out.
- hall_err, output, 1: sticky error; cleared only by rst.

Behaviour:
- Reset: all outputs are 0. The filter, counters, ring buffer and fill count are cleared. Internal sector is marked "unknown" and armed = 0.
- Synchroniser: 2-FF on hall. It runs regardless of ce.
- Filter:
  - A candidate code is held with a counter.
  - When the synced code differs from the accepted code, the counter runs while synced equals the candidate.
  - Any change in synced reloads the candidate and restarts the counter.
  - The accepted code updates on the FILTER_CYCLES-th consecutive matching cycle.
  - Total latency is hall pin change at edge N to accepted code at edge N+FILTER_CYCLES+2.
- Decode: 001→0, 011→1, 010→2, 110→3, 100→4, 101→5.
  - An accepted 000 or 111 sets hall_err. It is otherwise ignored: position and sector hold, and the interval counter keeps running.
- Interval counter:
  - Counts ce cycles and saturates at TIMEOUT_CYCLES.
  - It is loaded with 1 on each accepted sector change, so the captured interval equals the cycle count between accepted changes.
- On accepted valid sector change (classified against the previous sector):
  - From unknown: set position, set direction per the next move only, set armed = 1. No interval is pushed.
  - To prev+1 mod 6 (forward) or prev−1 mod 6 (reverse), with direction unchanged and armed = 1: push the captured interval into a 6-entry ring buffer.
    - running sum ← sum + new − evicted entry. fill count saturates at 6.
    - When fill = 6 after the push: motor_speed ← new sum and new_motor_speed pulses. The pulse lands at hall pin edge N+FILTER_CYCLES+3.
  - Adjacent step with direction reversed: update direction, clear buffer, sum and fill, discard the interval, keep armed.
  - Non-adjacent (skipped sector): set hall_err, clear buffer, discard the interval, keep armed.
  - Every valid change updates position, clears stalled and restarts the counter.
- Timeout: when the counter reaches TIMEOUT_CYCLES while stalled = 0:
  - stalled ← 1, motor_speed ← 0, single new_motor_speed pulse.
  - Buffer is cleared, armed ← 0.
  - No further pulses occur until a full revolution is measured again.
- Simultaneous timeout and accepted change in the same cycle: the change wins and no stall is declared.
- ce = 0: no state advances and new_motor_speed is forced to 0. A strobe is never stretched.
- rst mid-measurement: immediate return to reset state. The first post-reset transition only arms.

Test Plan (FILTER_CYCLES=4, TIMEOUT_CYCLES=1000, ce=1):
- Reset check: rst for 3 cycles with hall=001 → all outputs 0. After rst falls, position=0 after 6 cycles and no strobe.
- Forward rotation: step 001→011→010→110→100→101→001 every 100 cycles → no strobe for the first 6 changes. On the 7th change, motor_speed=600 and direction=1, with the strobe exactly 7 cycles after the pin edge. Later strobes occur every 100 cycles.
- Glitch rejection: during steady rotation, a 3-cycle pulse to the next code → position, motor_speed and the strobe are unaffected. The same pulse held 4 cycles is accepted.
- Stall: stop the Hall lines after motor_speed=600 → stalled=1 and motor_speed=0 with one strobe 1000 cycles after the last change. A subsequent step clears stalled, with no strobe until 6 more intervals.
- Reversal: after forward lock, step 3→2 → direction=0 and the buffer is cleared. The next strobe comes only after 6 further reverse intervals, with the correct sum (e.g. 6×150=900).
- Faults: hall=111 held 10 cycles → hall_err=1, position unchanged. Skip 1→3 → hall_err stays 1 and the buffer is cleared. Only rst clears hall_err.
